// File: rtl/me_frame_scheduler_if.sv
// Bundle between me_frame_scheduler and the host, the me_top core and the result consumer.
// Optional ME_FRAME_SCHEDULER_TIMEOUT_EN adds the sticky timeout flag.
interface me_frame_scheduler_if #(
    parameter int TB_LENGTH    = 16,
    parameter int SW_LENGTH    = 64,
    parameter int PE_OUT_WIDTH = 8,
    parameter int NUM_MB       = 4
);
    localparam int RANGE     = SW_LENGTH - TB_LENGTH + 1;
    localparam int CNT_WIDTH = $clog2(RANGE * RANGE);
    localparam int SAD_WIDTH = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH;
    localparam int MV_WIDTH  = $clog2(RANGE);
    localparam int MB_WIDTH  = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 me_req;
    logic                 me_ack;
    logic [CNT_WIDTH-1:0] me_min_cnt;
    logic [SAD_WIDTH-1:0] me_min_sad;
    logic [MB_WIDTH-1:0]  mb_idx;
    logic                 res_valid;
    logic                 res_ready;
    logic [MB_WIDTH-1:0]  res_mb;
    logic [MV_WIDTH-1:0]  res_mv_x;
    logic [MV_WIDTH-1:0]  res_mv_y;
    logic [SAD_WIDTH-1:0] res_sad;
`ifdef ME_FRAME_SCHEDULER_TIMEOUT_EN
    logic                 timeout;
`endif

    modport master (
        input  start, me_ack, me_min_cnt, me_min_sad, res_ready,
        output busy, done, me_req, mb_idx, res_valid, res_mb, res_mv_x, res_mv_y, res_sad
`ifdef ME_FRAME_SCHEDULER_TIMEOUT_EN
        , output timeout
`endif
    );

    modport slave (
        output start, me_ack, me_min_cnt, me_min_sad, res_ready,
        input  busy, done, me_req, mb_idx, res_valid, res_mb, res_mv_x, res_mv_y, res_sad
`ifdef ME_FRAME_SCHEDULER_TIMEOUT_EN
        , input timeout
`endif
    );
endinterface

// File: rtl/me_frame_scheduler.sv
// Frame-level sequencer for me_top: per macroblock a four-phase req/ack, min_cnt -> (mv_x, mv_y)
// by iterative subtraction, one valid/ready result. ME_FRAME_SCHEDULER_TIMEOUT_EN adds an ack watchdog.
module me_frame_scheduler #(
    parameter int TB_LENGTH    = 16,
    parameter int SW_LENGTH    = 64,
    parameter int PE_OUT_WIDTH = 8,
    parameter int NUM_MB       = 4
`ifdef ME_FRAME_SCHEDULER_TIMEOUT_EN
    , parameter int TIMEOUT    = 8192
`endif
) (
    input logic clk,
    input logic rst,
    me_frame_scheduler_if.master bus
);
    localparam int RANGE     = SW_LENGTH - TB_LENGTH + 1;
    localparam int CNT_WIDTH = $clog2(RANGE * RANGE);
    localparam int SAD_WIDTH = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH;
    localparam int MV_WIDTH  = $clog2(RANGE);
    localparam int MB_WIDTH  = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;

    localparam logic [CNT_WIDTH-1:0] RANGE_C = CNT_WIDTH'(RANGE);
    localparam logic [MB_WIDTH-1:0]  LAST_MB = MB_WIDTH'(NUM_MB - 1);

    typedef enum logic [2:0] {IDLE, REQ, REL, DIV, OUT} state_t;

    state_t               state;
    logic                 busy_r, done_r, me_req_r, res_valid_r;
    logic [MB_WIDTH-1:0]  mb_idx_r, res_mb_r;
    logic [MV_WIDTH-1:0]  res_mv_x_r, res_mv_y_r, quo;
    logic [SAD_WIDTH-1:0] res_sad_r;
    logic [CNT_WIDTH-1:0] rem;

`ifdef ME_FRAME_SCHEDULER_TIMEOUT_EN
    localparam int TMO_WIDTH = $clog2(TIMEOUT + 1);
    logic [TMO_WIDTH-1:0] tmo_cnt;
    logic                 timeout_r;
    logic                 ack_evt;

    // the edge each handshake state is waiting on; anything else counts toward the watchdog
    assign ack_evt = ((state == REQ) && me_req_r && bus.me_ack) ||
                     ((state == REL) && !bus.me_ack);
    assign bus.timeout = timeout_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            me_req_r    <= 1'b0;
            res_valid_r <= 1'b0;
            mb_idx_r    <= '0;
            res_mb_r    <= '0;
            res_mv_x_r  <= '0;
            res_mv_y_r  <= '0;
            res_sad_r   <= '0;
            rem         <= '0;
            quo         <= '0;
`ifdef ME_FRAME_SCHEDULER_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // done_r is high only in the first IDLE cycle; a start there is dropped
                    if (bus.start && !done_r) begin
                        mb_idx_r <= '0;
                        busy_r   <= 1'b1;
                        state    <= REQ;
`ifdef ME_FRAME_SCHEDULER_TIMEOUT_EN
                        timeout_r <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (me_req_r && bus.me_ack) begin
                        rem       <= bus.me_min_cnt;
                        res_sad_r <= bus.me_min_sad;
                        quo       <= '0;
                        me_req_r  <= 1'b0;
                        state     <= REL;
                    end else if (!bus.me_ack) begin
                        // a stale ack keeps req low until the core has released it
                        me_req_r <= 1'b1;
                    end
                end
                REL: begin
                    if (!bus.me_ack) state <= DIV;
                end
                DIV: begin
                    if (rem >= RANGE_C) begin
                        rem <= rem - RANGE_C;
                        if (quo != '1) quo <= quo + MV_WIDTH'(1);
                    end else begin
                        res_mv_x_r  <= rem[MV_WIDTH-1:0];
                        res_mv_y_r  <= quo;
                        res_mb_r    <= mb_idx_r;
                        res_valid_r <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        if (mb_idx_r == LAST_MB) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            mb_idx_r <= mb_idx_r + MB_WIDTH'(1);
                            state    <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef ME_FRAME_SCHEDULER_TIMEOUT_EN
            // overrides the case above when the watchdog expires
            if (state == REQ || state == REL) begin
                if (ack_evt) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TMO_WIDTH'(TIMEOUT - 1)) begin
                    tmo_cnt     <= '0;
                    me_req_r    <= 1'b0;
                    timeout_r   <= 1'b1;
                    res_sad_r   <= '1;
                    res_mv_x_r  <= '0;
                    res_mv_y_r  <= '0;
                    res_mb_r    <= mb_idx_r;
                    res_valid_r <= 1'b1;
                    state       <= OUT;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
                end
            end
`endif
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.me_req    = me_req_r;
    assign bus.mb_idx    = mb_idx_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_mb    = res_mb_r;
    assign bus.res_mv_x  = res_mv_x_r;
    assign bus.res_mv_y  = res_mv_y_r;
    assign bus.res_sad   = res_sad_r;
endmodule

// File: doc/me_frame_scheduler.md
Name: me_frame_scheduler

Overview:
- Sequences the full-search motion estimation core (me_top) across NUM_MB macroblocks of one frame.
- For each macroblock: drives the macroblock index, runs a four-phase req/ack transaction with the core, captures min_cnt/min_sad, converts min_cnt into a motion vector (mv_x, mv_y), then presents one result per macroblock on a valid/ready output port.
- Sits between the frame-level host control (start/busy/done) and me_top.

Parameters:
- TB_LENGTH, 16, template block edge in pixels.
- SW_LENGTH, 64, search window edge in pixels.
- PE_OUT_WIDTH, 8, PE absolute-difference width.
- NUM_MB, 4, macroblocks per frame; minimum 1.
- Derived (localparams): RANGE=SW_LENGTH-TB_LENGTH+1 (49); CNT_WIDTH=$clog2(RANGE**2) (12); SAD_WIDTH=$clog2(TB_LENGTH**2)+PE_OUT_WIDTH (16); MV_WIDTH=$clog2(RANGE) (6); MB_WIDTH=max(1,$clog2(NUM_MB)).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a frame when in IDLE, ignored otherwise.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last result is accepted.
- me_req  out  1  request to me_top.
- me_ack  in  1  acknowledge from me_top.
- me_min_cnt  in  CNT_WIDTH  best candidate index from me_top.
- me_min_sad  in  SAD_WIDTH  best SAD from me_top.
- mb_idx  out  MB_WIDTH  macroblock currently being processed; drives core address base.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_mb  out  MB_WIDTH  macroblock index of the result.
- res_mv_x  out  MV_WIDTH  min_cnt mod RANGE.
- res_mv_y  out  MV_WIDTH  min_cnt div RANGE.
- res_sad  out  SAD_WIDTH  captured min_sad.

Behaviour:
- Reset: all outputs 0; state IDLE; mb_idx=0. Reset asserted mid-frame aborts immediately, and me_req falls in the same edge.
- States: IDLE, REQ, REL, DIV, OUT.
- IDLE: on start=1, mb_idx<=0, busy<=1, go to REQ.
- REQ: me_req=1. On the first cycle me_ack is sampled 1, latch me_min_cnt into a remainder register and me_min_sad into res_sad, clear the quotient, go to REL.
- REL: me_req=0; wait for me_ack=0, then go to DIV. Four-phase protocol: me_req is never reasserted while me_ack is high.
- DIV: iterative subtraction, one per cycle. While remainder>=RANGE: remainder-=RANGE, quotient+=1. When remainder<RANGE: res_mv_x<=remainder, res_mv_y<=quotient, res_mb<=mb_idx, go to OUT.
  - Latency is quotient+1 cycles; maximum RANGE cycles for min_cnt=RANGE**2-1.
- OUT: res_valid=1; outputs stay stable until res_valid&&res_ready.
  - On transfer with mb_idx==NUM_MB-1: res_valid<=0, busy<=0, done pulses 1 cycle, go to IDLE.
  - Otherwise: mb_idx+=1, go to REQ.
- start while busy is ignored. A start in the same cycle as done is ignored; start is accepted only in IDLE.
- me_ack high on entry to REQ (stale ack): stay in REQ with me_req=0 until me_ack=0, then assert me_req.
- min_cnt >= RANGE**2 is outside the contract; the divider still terminates (the quotient saturates at its width) and no check is made.
- With NUM_MB=1, mb_idx stays 0.

Optional Feature:
- Macro: ME_FRAME_SCHEDULER_TIMEOUT_EN.
- With the macro defined:
  - Add parameter TIMEOUT (default 8192) and output timeout (1 bit, sticky, cleared by rst or an accepted start).
  - A counter runs in REQ and REL. If it reaches TIMEOUT cycles without the awaited ack edge: drop me_req, set timeout=1, res_sad<=all ones, res_mv_x=res_mv_y=0, skip DIV, go to OUT.
  - The frame continues with the next macroblock.
- Without the macro: no counter, no timeout port; the scheduler waits indefinitely.

Test Plan:
- Reset, then start with an ack model (ack 3 cycles after req, drops 2 cycles after req falls), NUM_MB=4, res_ready=1 -> four results with res_mb 0..3, busy high throughout, single done pulse, me_req never high while me_ack is high.
- min_cnt=0 -> mv=(0,0), DIV lasts 1 cycle. min_cnt=2400 -> mv_x=48, mv_y=48, DIV lasts 49 cycles. min_cnt=100 -> mv_x=2, mv_y=2. res_sad equals the injected sad, e.g. 16'h1234.
- res_ready held low 20 cycles in OUT -> res_* stable, me_req stays 0, mb_idx unchanged; transfer on the ready rise.
- rst pulsed while in REQ on macroblock 2 -> next cycle all outputs 0; a new start restarts at mb_idx 0.
- start pulses during busy and in the done cycle -> ignored, exactly 4 results; me_ack high at start -> me_req held until ack falls.
- With ME_FRAME_SCHEDULER_TIMEOUT_EN and TIMEOUT=16, core never acks on macroblock 1 -> after 16 cycles timeout=1, result mb 1 has sad 16'hFFFF, macroblocks 2 and 3 complete normally.
